instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 59 +++++
 rtl/instr_field_pack.sv | 54 +++++
 rtl/instr_encoder.sv | 117 +++++++++++
 tb/tb_instr_encoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: mnemonic codes, MIPS
// opcode/funct constants and small word-assembly helpers.
package instr_encoder_pkg;

    // Mnemonic codes carried on in_op; codes 25..31 are illegal.
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_OR   = 5'd2,  OP_SLL  = 5'd3,
        OP_SRL  = 5'd4,  OP_SRA  = 5'd5,  OP_JR   = 5'd6,  OP_ORI  = 5'd7,
        OP_LW   = 5'd8,  OP_SW   = 5'd9,  OP_LB   = 5'd10, OP_LBU  = 5'd11,
        OP_LH   = 5'd12, OP_SB   = 5'd13, OP_SH   = 5'd14, OP_BEQ  = 5'd15,
        OP_LUI  = 5'd16, OP_BGEZ = 5'd17, OP_BLTZ = 5'd18, OP_BGTZ = 5'd19,
        OP_BLEZ = 5'd20, OP_BNE  = 5'd21, OP_J    = 5'd22, OP_JAL  = 5'd23,
        OP_NOP  = 5'd24
    } op_e;

    // Primary opcodes (instruction bits 31:26)
    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_BNE     = 6'b000101;
    localparam logic [5:0] OPC_BLEZ    = 6'b000110;
    localparam logic [5:0] OPC_BGTZ    = 6'b000111;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LB      = 6'b100000;
    localparam logic [5:0] OPC_LH      = 6'b100001;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_LBU     = 6'b100100;
    localparam logic [5:0] OPC_SB      = 6'b101000;
    localparam logic [5:0] OPC_SH      = 6'b101001;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    // R-type function codes (instruction bits 5:0)
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OPC_SPECIAL, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: mnemonic plus operand fields -> 32-bit MIPS word and
// a legal flag. Optional branch group (bgez/bltz/bgtz/blez/bne) is enabled by
// the ENC_BRANCH_EXT_EN macro; without it those codes report illegal.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // Select the encoding for the mnemonic; unknown codes give word 0, illegal.
    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        case (op)
            OP_ADD:  word = r_word(rs, rt, rd, shamt, FN_ADD);
            OP_SUB:  word = r_word(rs, rt, rd, shamt, FN_SUB);
            OP_OR:   word = r_word(rs, rt, rd, shamt, FN_OR);
            OP_SLL:  word = r_word(5'd0, rt, rd, shamt, FN_SLL);
            OP_SRL:  word = r_word(5'd0, rt, rd, shamt, FN_SRL);
            OP_SRA:  word = r_word(5'd0, rt, rd, shamt, FN_SRA);
            OP_JR:   word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            OP_LW:   word = i_word(OPC_LW,  rs, rt, imm);
            OP_SW:   word = i_word(OPC_SW,  rs, rt, imm);
            OP_LB:   word = i_word(OPC_LB,  rs, rt, imm);
            OP_LBU:  word = i_word(OPC_LBU, rs, rt, imm);
            OP_LH:   word = i_word(OPC_LH,  rs, rt, imm);
            OP_SB:   word = i_word(OPC_SB,  rs, rt, imm);
            OP_SH:   word = i_word(OPC_SH,  rs, rt, imm);
            OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
            OP_LUI:  word = i_word(OPC_LUI, 5'd0, rt, imm);
`ifdef ENC_BRANCH_EXT_EN
            OP_BGEZ: word = i_word(OPC_REGIMM, rs, RT_BGEZ, imm);
            OP_BLTZ: word = i_word(OPC_REGIMM, rs, RT_BLTZ, imm);
            OP_BGTZ: word = i_word(OPC_BGTZ, rs, 5'd0, imm);
            OP_BLEZ: word = i_word(OPC_BLEZ, rs, 5'd0, imm);
            OP_BNE:  word = i_word(OPC_BNE,  rs, rt, imm);
`endif
            OP_J:    word = {OPC_J, target};
            OP_JAL:  word = {OPC_JAL, target};
            OP_NOP:  word = 32'h0000_0000;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts mnemonic requests, packs them into MIPS words,
// tags each with a running address and queues them in a 2-entry FIFO.
// Illegal mnemonics raise a one-cycle err pulse and bump a saturating count.
// Optional macro: ENC_BRANCH_EXT_EN (enables the extended branch group).
//
// Handshake: on both sides a transfer happens on a rising clk edge where
// valid and ready are both 1; valid never waits on ready, and the presented
// out_instr/out_addr hold steady while out_valid=1 and out_ready=0.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    logic [31:0] pack_word;
    logic        pack_legal;
    logic [1:0]  count;
    logic [31:0] addr_cnt;
    logic [31:0] head_instr, head_addr;   // slot 0: presented word
    logic [31:0] tail_instr, tail_addr;   // slot 1: waiting behind the head
    logic        accept, push, pop;

    instr_field_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    assign in_ready  = (count != 2'd2) && !flush;
    assign accept    = in_valid && in_ready;
    assign push      = accept && pack_legal;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != 2'd0);
    assign out_instr = head_instr;
    assign out_addr  = head_addr;

    // Shift-style FIFO and address counter; flush beats any same-cycle push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= 2'd0;
            addr_cnt   <= BASE_ADDR;
            head_instr <= 32'h0000_0000;
            head_addr  <= BASE_ADDR;
            tail_instr <= 32'h0000_0000;
            tail_addr  <= BASE_ADDR;
        end else if (flush) begin
            count    <= 2'd0;
            addr_cnt <= BASE_ADDR;
        end else begin
            if (push) begin
                addr_cnt <= addr_cnt + 32'd4;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_instr <= pack_word;
                        head_addr  <= addr_cnt;
                    end else begin
                        tail_instr <= pack_word;
                        tail_addr  <= addr_cnt;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_instr <= tail_instr;
                    head_addr  <= tail_addr;
                    count      <= count - 2'd1;
                end
                // push with pop only happens at count 1 (full blocks push)
                2'b11: begin
                    head_instr <= pack_word;
                    head_addr  <= addr_cnt;
                end
                default: ;
            endcase
        end
    end

    // Illegal-op pulse and saturating count; flush leaves the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            err <= accept && !pack_legal;
            if (accept && !pack_legal && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// queue-based behavioural model.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = 5'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_addr;
    logic        err;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // model state
    logic [31:0] exp_q[$];
    logic [31:0] exp_a[$];
    logic [31:0] m_addr = BASE;
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    // words actually handed out by the DUT, in order
    logic [31:0] obs_i[$];
    logic [31:0] obs_a[$];

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input int op);
        if (op > 24) return 1'b0;
`ifndef ENC_BRANCH_EXT_EN
        if (op >= 17 && op <= 21) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] rt_w(input logic [31:0] rs, rt, rd, sh, fn);
        return (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
    endfunction

    function automatic logic [31:0] it_w(input logic [31:0] opc, rs, rt, imm);
        return (opc << 26) | (rs << 21) | (rt << 16) | imm;
    endfunction

    // opcode / funct numbers written as decimals of the architectural binaries
    function automatic logic [31:0] ref_word(input int op, input logic [31:0] rs, rt, rd,
                                             sh, imm, tgt);
        case (op)
            0:  return rt_w(rs, rt, rd, sh, 32);
            1:  return rt_w(rs, rt, rd, sh, 34);
            2:  return rt_w(rs, rt, rd, sh, 37);
            3:  return rt_w(0, rt, rd, sh, 0);
            4:  return rt_w(0, rt, rd, sh, 2);
            5:  return rt_w(0, rt, rd, sh, 3);
            6:  return rt_w(rs, 0, 0, 0, 8);
            7:  return it_w(13, rs, rt, imm);
            8:  return it_w(35, rs, rt, imm);
            9:  return it_w(43, rs, rt, imm);
            10: return it_w(32, rs, rt, imm);
            11: return it_w(36, rs, rt, imm);
            12: return it_w(33, rs, rt, imm);
            13: return it_w(40, rs, rt, imm);
            14: return it_w(41, rs, rt, imm);
            15: return it_w(4,  rs, rt, imm);
            16: return it_w(15, 0,  rt, imm);
            17: return it_w(1,  rs, 1,  imm);
            18: return it_w(1,  rs, 0,  imm);
            19: return it_w(7,  rs, 0,  imm);
            20: return it_w(6,  rs, 0,  imm);
            21: return it_w(5,  rs, rt, imm);
            22: return (32'd2 << 26) | tgt;
            23: return (32'd3 << 26) | tgt;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- compare process + scoreboard ----------------
    always @(negedge clk) begin
        bit m_ready, acc, lg;
        if (reset) begin
            exp_q.delete();
            exp_a.delete();
            m_addr = BASE;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            m_ready = (exp_q.size() < 2) && !flush;
            check("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("out_instr", out_instr, exp_q[0]);
                check("out_addr", out_addr, exp_a[0]);
            end
            check("err", {31'd0, err}, {31'd0, m_err});
            check("err_cnt", {24'd0, err_cnt}, m_cnt);
            if (out_valid && out_ready) begin
                obs_i.push_back(out_instr);
                obs_a.push_back(out_addr);
            end
            acc = in_valid && m_ready;
            lg  = ref_legal(int'(in_op));
            if (flush) begin
                exp_q.delete();
                exp_a.delete();
                m_addr = BASE;
            end else begin
                if (exp_q.size() != 0 && out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_a.pop_front());
                end
                if (acc && lg) begin
                    exp_q.push_back(ref_word(int'(in_op), in_rs, in_rt, in_rd, in_shamt,
                                             in_imm, in_target));
                    exp_a.push_back(m_addr);
                    m_addr = m_addr + 32'd4;
                end
            end
            m_err = acc && !lg;
            if (m_err && m_cnt != 255) m_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs_i.delete();
        obs_a.delete();
    endtask

    task automatic push(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt);
        int guard = 0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0 for op %0d", op);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit c_done;
        int guard;

        do_reset();

        // first word into an empty queue appears one cycle later
        out_ready = 1'b0;
        push(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_instr", out_instr, 32'h0022_1820);
        check("add_addr", out_addr, 32'h0000_3000);
        idle(2);
        check("hold_instr", out_instr, 32'h0022_1820);

        // ori then jal, draining continuously
        do_reset();
        out_ready = 1'b1;
        push(5'd7, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0);
        push(5'd23, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0C03);
        idle(3);
        check("seq_count", obs_i.size(), 32'd2);
        if (obs_i.size() == 2) begin
            check("ori_instr", obs_i[0], 32'h3401_1234);
            check("ori_addr", obs_a[0], 32'h0000_3000);
            check("jal_instr", obs_i[1], 32'h0C00_0C03);
            check("jal_addr", obs_a[1], 32'h0000_3004);
        end

        // bgez: encoded with the branch extension, illegal without it
        do_reset();
        push(5'd17, 5'd5, 5'd0, 5'd0, 5'd0, 16'd4, 26'd0);
        idle(3);
`ifdef ENC_BRANCH_EXT_EN
        check("bgez_count", obs_i.size(), 32'd1);
        if (obs_i.size() == 1) check("bgez_instr", obs_i[0], 32'h04A1_0004);
        check("bgez_err_cnt", {24'd0, err_cnt}, 32'd0);
`else
        check("bgez_count", obs_i.size(), 32'd0);
        check("bgez_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif

        // back-pressure: third request waits for a pop
        do_reset();
        out_ready = 1'b0;
        push(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 26'd0);
        push(5'd8, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'd0);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        c_done = 1'b0;
        fork
            begin
                push(5'd22, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0123);
                c_done = 1'b1;
            end
        join_none
        idle(3);
        check("full_hold_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_head", out_instr, 32'h0085_3022);
        out_ready = 1'b1;
        guard = 0;
        while (!c_done && guard < 300) begin
            guard++;
            idle(1);
        end
        check("third_done", {31'd0, c_done}, 32'd1);
        idle(4);
        check("bp_count", obs_i.size(), 32'd3);
        if (obs_i.size() == 3) begin
            check("bp_i0", obs_i[0], 32'h0085_3022);
            check("bp_i1", obs_i[1], 32'h8C43_0010);
            check("bp_i2", obs_i[2], 32'h0800_0123);
            check("bp_a0", obs_a[0], 32'h0000_3000);
            check("bp_a1", obs_a[1], 32'h0000_3004);
            check("bp_a2", obs_a[2], 32'h0000_3008);
        end

        // illegal op: error pulse, address untouched, count saturates
        do_reset();
        push(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'd0);
        check("ill_err", {31'd0, err}, 32'd1);
        idle(1);
        check("ill_err_drop", {31'd0, err}, 32'd0);
        check("ill_err_cnt", {24'd0, err_cnt}, 32'd1);
        push(5'd16, 5'd7, 5'd1, 5'd0, 5'd0, 16'hABCD, 26'd0);
        idle(3);
        check("ill_next_count", obs_i.size(), 32'd1);
        if (obs_i.size() == 1) begin
            check("lui_instr", obs_i[0], 32'h3C01_ABCD);
            check("lui_addr", obs_a[0], 32'h0000_3000);
        end
        in_op = 5'd31;
        in_valid = 1'b1;
        idle(256);
        in_valid = 1'b0;
        idle(2);
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

        // flush with two queued words and a same-cycle request
        do_reset();
        out_ready = 1'b0;
        push(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        push(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
        push(5'd3, 5'd0, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        in_op = 5'd0;
        in_valid = 1'b1;
        #1;
        check("flush_ready", {31'd0, in_ready}, 32'd0);
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_err_cnt", {24'd0, err_cnt}, 32'd1);
        obs_i.delete();
        obs_a.delete();
        push(5'd24, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1111, 26'h111);
        idle(3);
        check("post_flush_count", obs_i.size(), 32'd1);
        if (obs_i.size() == 1) begin
            check("nop_instr", obs_i[0], 32'h0);
            check("nop_addr", obs_a[0], 32'h0000_3000);
        end

        // reset while words are queued discards them
        out_ready = 1'b0;
        push(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
        push(5'd0, 5'd2, 5'd2, 5'd2, 5'd0, 16'd0, 26'd0);
        do_reset();
        idle(1);
        check("post_reset_valid", {31'd0, out_valid}, 32'd0);

        // randomized traffic, checked by the compare process
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 5'($urandom_range(0, 31));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_shamt  = 5'($urandom);
            in_imm    = 16'($urandom);
            in_target = 26'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            idle(1);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
